// File: rtl/crt_timing_pkg.sv
// Default 640x480@60 timing constants, RGB field widths and the colour-bar palette
// shared by the CRT timing generator and its axis counters.
package crt_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  localparam int RED_W   = 3;
  localparam int GREEN_W = 3;
  localparam int BLUE_W  = 2;
  localparam int RGB_W   = RED_W + GREEN_W + BLUE_W;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_YELLOW,
    BAR_CYAN,
    BAR_GREEN,
    BAR_MAGENTA,
    BAR_RED,
    BAR_BLUE,
    BAR_BLACK
  } bar_e;

  // Palette entries packed as {r[2:0], g[2:0], b[1:0]}.
  localparam logic [RGB_W-1:0] COL_WHITE   = 8'hFF;
  localparam logic [RGB_W-1:0] COL_YELLOW  = 8'hFC;
  localparam logic [RGB_W-1:0] COL_CYAN    = 8'h1F;
  localparam logic [RGB_W-1:0] COL_GREEN   = 8'h1C;
  localparam logic [RGB_W-1:0] COL_MAGENTA = 8'hE3;
  localparam logic [RGB_W-1:0] COL_RED     = 8'hE0;
  localparam logic [RGB_W-1:0] COL_BLUE    = 8'h03;
  localparam logic [RGB_W-1:0] COL_BLACK   = 8'h00;

  function automatic logic [RGB_W-1:0] bar_colour(input bar_e bar);
    case (bar)
      BAR_WHITE:   return COL_WHITE;
      BAR_YELLOW:  return COL_YELLOW;
      BAR_CYAN:    return COL_CYAN;
      BAR_GREEN:   return COL_GREEN;
      BAR_MAGENTA: return COL_MAGENTA;
      BAR_RED:     return COL_RED;
      BAR_BLUE:    return COL_BLUE;
      default:     return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/crt_axis_counter.sv
// One display axis: enable-gated wrap counter with visible-region and sync-region decode.
module crt_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACTIVE_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG   = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign wrap_o   = (cnt_q == LAST);
  assign active_o = (cnt_q < ACTIVE_END);
  assign sync_o   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

endmodule

// File: rtl/crt_timing_gen.sv
// VGA/CRT timing generator and blanked RGB output stage for the Pong display path.
// Define CRT_TESTBARS_EN to add the eight-bar colour test pattern selected by test_mode_i.
module crt_timing_gen
  import crt_timing_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_ACTIVE  = DEF_H_ACTIVE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACTIVE  = DEF_V_ACTIVE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CNT_W     = DEF_CNT_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [RGB_W-1:0]   rgb_in_i,
  input  logic               test_mode_i,
  output logic               pix_ce_o,
  output logic [CNT_W-1:0]   xpos_o,
  output logic [CNT_W-1:0]   ypos_o,
  output logic               active_o,
  output logic               frame_start_o,
  output logic [RED_W-1:0]   red_o,
  output logic [GREEN_W-1:0] green_o,
  output logic [BLUE_W-1:0]  blue_o,
  output logic               hsync_o,
  output logic               vsync_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_ce_q;

  // pix_ce is registered against the next divider value so it lines up with div_q == CLK_DIV-1.
  assign div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= (div_d == DIV_LAST);
    end
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_act, h_sync, v_act, v_sync, v_wrap_unused;

  crt_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h_axis (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(pix_ce_q),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
  );

  crt_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v_axis (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(pix_ce_q & h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap_unused), .active_o(v_act), .sync_o(v_sync)
  );

  // Stage 0 publishes the counter position one pixel after reset release, so
  // active rises together with position (0,0).
  logic [CNT_W-1:0] xpos_q, ypos_q;
  logic active_q, hs0_q, vs0_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xpos_q   <= '0;
      ypos_q   <= '0;
      active_q <= 1'b0;
      hs0_q    <= 1'b0;
      vs0_q    <= 1'b0;
    end else if (pix_ce_q) begin
      xpos_q   <= h_cnt;
      ypos_q   <= v_cnt;
      active_q <= h_act & v_act;
      hs0_q    <= h_sync;
      vs0_q    <= v_sync;
    end
  end

  logic [RGB_W-1:0] pix_d;

`ifdef CRT_TESTBARS_EN
  localparam logic [CNT_W+2:0] BAR_DIV = (CNT_W + 3)'(H_ACTIVE);
  logic [2:0] bar_idx;

  assign bar_idx = 3'({xpos_q, 3'b000} / BAR_DIV);

  always_comb begin
    pix_d = '0;
    if (active_q) begin
      pix_d = test_mode_i ? bar_colour(bar_e'(bar_idx)) : rgb_in_i;
    end
  end
`else
  logic test_mode_unused;

  assign test_mode_unused = test_mode_i;

  always_comb begin
    pix_d = '0;
    if (active_q) begin
      pix_d = rgb_in_i;
    end
  end
`endif

  // Stage 1 drives the pins; syncs come from stage 0 so they stay aligned with the pixel.
  logic [RGB_W-1:0] rgb_q;
  logic hsync_q, vsync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_q   <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else if (pix_ce_q) begin
      rgb_q   <= pix_d;
      hsync_q <= hs0_q ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= vs0_q ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign pix_ce_o      = pix_ce_q;
  assign xpos_o        = xpos_q;
  assign ypos_o        = ypos_q;
  assign active_o      = active_q;
  assign frame_start_o = pix_ce_q & active_q & (xpos_q == '0) & (ypos_q == '0);
  assign red_o         = rgb_q[RGB_W-1 -: RED_W];
  assign green_o       = rgb_q[BLUE_W +: GREEN_W];
  assign blue_o        = rgb_q[BLUE_W-1:0];
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;

endmodule
